// File: rtl/instruction_cache_ctrl.sv
// ---------------------------------------------------------------------------
// instruction_cache_ctrl
//
// Direct-mapped, read-only instruction cache sitting between the CPU fetch
// stage and a 1024-byte instruction memory. Eight lines of 16 bytes each.
// A hit returns the 32-bit word combinationally; a miss stalls the CPU,
// reads one 128-bit block from memory, installs it and then completes as a
// hit on the following IDLE cycle.
//
// Address split: word offset pc[3:2], index pc[6:4], tag pc[9:7].
//
// Ports:
//   clock         in   1    system clock, rising edge
//   reset         in   1    asynchronous reset, active low
//   read          in   1    CPU fetch request (held while busywait = 1)
//   pc            in   10   byte address, pc[1:0] ignored
//   instruction   out  32   fetched word, valid when read && !busywait
//   busywait      out  1    CPU stall
//   mem_read      out  1    block read request to instruction memory
//   mem_address   out  6    block address being refilled
//   mem_readinst  in   128  block data, byte 0 in bits [7:0]
//   mem_busywait  in   1    memory busy
//   hit_count     out  16   saturating hit counter (stats build only)
//   miss_count    out  16   saturating miss counter (stats build only)
//
// Build option:
//   ICACHE_STATS_EN  when defined, hit_count/miss_count are live saturating
//                    counters; otherwise both are tied to zero and no
//                    counter flops exist.
// ---------------------------------------------------------------------------
module instruction_cache_ctrl #(
   parameter int unsigned NUM_SETS = 8,
   parameter int unsigned TAG_BITS = 3
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         read,
   input  logic [9:0]   pc,
   output logic [31:0]  instruction,
   output logic         busywait,
   output logic         mem_read,
   output logic [5:0]   mem_address,
   input  logic [127:0] mem_readinst,
   input  logic         mem_busywait,
   output logic [15:0]  hit_count,
   output logic [15:0]  miss_count
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_MEM_READ = 2'd1,
      S_UPDATE   = 2'd2
   } state_e;

   state_e state_q, state_d;

   // cache storage
   logic                valid_q [NUM_SETS];
   logic [TAG_BITS-1:0] tag_q   [NUM_SETS];
   logic [127:0]        data_q  [NUM_SETS];

   // refill bookkeeping
   logic [5:0] blk_q;        // block address latched on the miss edge
   logic       first_q;      // high during the mandatory MEM_READ entry cycle
   logic       mem_read_q;

   // address fields
   logic [1:0] offset;
   logic [2:0] index;
   logic [2:0] tag;
   logic       hit;
   logic       unused_pc;

   assign offset    = pc[3:2];
   assign index     = pc[6:4];
   assign tag       = pc[9:7];
   assign unused_pc = ^pc[1:0];

   assign hit         = valid_q[index] && (tag_q[index] == tag);
   assign instruction = data_q[index][{offset, 5'b00000} +: 32];

   assign mem_read    = mem_read_q;
   assign mem_address = blk_q;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (read && !hit) begin
               state_d = S_MEM_READ;
            end
         end
         S_MEM_READ: begin
            // The entry cycle never completes, even if memory is idle.
            if (!first_q && !mem_busywait) begin
               state_d = S_UPDATE;
            end
         end
         S_UPDATE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   // busywait depends only on state, read and the current lookup, so a
   // stable hit in IDLE keeps it low without glitching.
   always_comb begin
      busywait = 1'b1;
      if (state_q == S_IDLE) begin
         busywait = read && !hit;
      end
   end

   // ------------------------------------------------------------------
   // Refill request registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         blk_q      <= '0;
         first_q    <= 1'b0;
         mem_read_q <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (state_d == S_MEM_READ) begin
                  blk_q      <= pc[9:4];
                  first_q    <= 1'b1;
                  mem_read_q <= 1'b1;
               end
            end
            S_MEM_READ: begin
               first_q <= 1'b0;
               if (state_d == S_UPDATE) begin
                  mem_read_q <= 1'b0;
               end
            end
            default: begin
               first_q    <= 1'b0;
               mem_read_q <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Cache arrays; the latched block is installed in UPDATE regardless of
   // where pc has moved since the miss.
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_SETS; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            data_q[i]  <= '0;
         end
      end else if (state_q == S_UPDATE) begin
         valid_q[blk_q[2:0]] <= 1'b1;
         tag_q[blk_q[2:0]]   <= blk_q[5:3];
         data_q[blk_q[2:0]]  <= mem_readinst;
      end
   end

   // ------------------------------------------------------------------
   // Optional statistics
   // ------------------------------------------------------------------
`ifdef ICACHE_STATS_EN
   logic [15:0] hit_cnt_q;
   logic [15:0] miss_cnt_q;
   logic        hit_evt;
   logic        miss_evt;

   // a miss event is exactly the IDLE -> MEM_READ transition
   assign hit_evt  = (state_q == S_IDLE) && read && hit;
   assign miss_evt = (state_q == S_IDLE) && read && !hit;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (hit_evt && (hit_cnt_q != '1)) begin
            hit_cnt_q <= hit_cnt_q + 16'd1;
         end
         if (miss_evt && (miss_cnt_q != '1)) begin
            miss_cnt_q <= miss_cnt_q + 16'd1;
         end
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule

// File: tb/tb_instruction_cache_ctrl.sv
module tb_instruction_cache_ctrl;

   logic         clock;
   logic         reset;
   logic         read;
   logic [9:0]   pc;
   logic [31:0]  instruction;
   logic         busywait;
   logic         mem_read;
   logic [5:0]   mem_address;
   logic [127:0] mem_readinst;
   logic         mem_busywait;
   logic [15:0]  hit_count;
   logic [15:0]  miss_count;

   instruction_cache_ctrl #(.NUM_SETS(8), .TAG_BITS(3)) dut (
      .clock        (clock),
      .reset        (reset),
      .read         (read),
      .pc           (pc),
      .instruction  (instruction),
      .busywait     (busywait),
      .mem_read     (mem_read),
      .mem_address  (mem_address),
      .mem_readinst (mem_readinst),
      .mem_busywait (mem_busywait),
      .hit_count    (hit_count),
      .miss_count   (miss_count)
   );

   int errors = 0;
   int checks = 0;

   // memory contents and memory latency (cycles of mem_busywait per request)
   logic [7:0] memb [1024];
   int         lat = 0;
   int         mcnt = 0;

   // reference model: which block each line holds, plus expected statistics
   bit         ref_v   [8];
   logic [5:0] ref_blk [8];
   int         exp_hits = 0;
   int         exp_miss = 0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // instruction memory: busy for 'lat' negedges per request, then delivers
   initial begin
      mem_busywait = 1'b0;
      mem_readinst = '0;
      forever begin
         @(negedge clock);
         if (mem_read === 1'b1) begin
            if (mcnt < lat) begin
               mem_busywait = 1'b1;
               mem_readinst = {$urandom, $urandom, $urandom, $urandom};
               mcnt++;
            end else begin
               mem_busywait = 1'b0;
               for (int i = 0; i < 16; i++)
                  mem_readinst[8*i +: 8] = memb[int'(mem_address) * 16 + i];
            end
         end else begin
            mcnt = 0;
            mem_busywait = 1'b0;
         end
      end
   end

   function automatic logic [31:0] ref_word(input logic [9:0] a);
      int b;
      b = int'({a[9:2], 2'b00});
      return {memb[b+3], memb[b+2], memb[b+1], memb[b]};
   endfunction

   function automatic bit model_hit(input logic [9:0] a);
      return ref_v[a[6:4]] && (ref_blk[a[6:4]] == a[9:4]);
   endfunction

   // cycles spent in MEM_READ: entry cycle plus wait, never fewer than two
   function automatic int mr_cycles();
      return (lat + 1 > 2) ? lat + 1 : 2;
   endfunction

   function automatic logic [15:0] exp_cnt(input int n);
`ifdef ICACHE_STATS_EN
      return (n > 65535) ? 16'hFFFF : 16'(n);
`else
      return (n >= 0) ? 16'h0000 : 16'h0000;
`endif
   endfunction

   task automatic model_fetch(input logic [9:0] a);
      if (!model_hit(a)) exp_miss++;
      exp_hits++;
      ref_v[a[6:4]]   = 1'b1;
      ref_blk[a[6:4]] = a[9:4];
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         ref_v[i]   = 1'b0;
         ref_blk[i] = '0;
      end
      exp_hits = 0;
      exp_miss = 0;
   endtask

   task automatic set_word(input int addr, input logic [31:0] w);
      for (int i = 0; i < 4; i++) memb[addr + i] = w[8*i +: 8];
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      reset = 1'b0;
      read  = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      model_reset();
   endtask

   // Drives one fetch and waits until it completes; read is held over the
   // completing edge (one hit) and then released.
   task automatic do_fetch(input logic [9:0] a, output int stalls,
                           output int mr_cyc, output int addr_bad,
                           output logic [31:0] instr);
      @(negedge clock);
      read = 1'b1;
      pc   = a;
      #1;
      stalls   = 0;
      mr_cyc   = 0;
      addr_bad = 0;
      forever begin
         if (mem_read === 1'b1) begin
            mr_cyc++;
            if (mem_address !== a[9:4]) addr_bad++;
         end
         if (busywait !== 1'b1 || stalls >= 2000) break;
         @(negedge clock);
         #1;
         stalls++;
      end
      instr = instruction;
      @(negedge clock);
      read = 1'b0;
   endtask

   task automatic test_reset();
      logic [9:0] pcs [4];
      pcs = '{10'h000, 10'h08C, 10'h1F4, 10'h3FC};
      @(negedge clock);
      #1;
      checks++;
      if (busywait !== 1'b0) begin errors++; $display("FAIL reset_busywait: got %b want 0", busywait); end
      checks++;
      if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
      checks++;
      if (mem_address !== 6'd0) begin errors++; $display("FAIL reset_mem_address: got %0h want 0", mem_address); end
      checks++;
      if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
         errors++; $display("FAIL reset_counters: got %0h/%0h want 0/0", hit_count, miss_count);
      end
      foreach (pcs[i]) begin
         pc = pcs[i];
         #1;
         checks++;
         if (instruction !== 32'd0) begin errors++; $display("FAIL reset_instruction: pc %0h got %0h want 0", pcs[i], instruction); end
      end
   endtask

   // runs a list of fetches and checks each against the reference model
   task automatic run_list(input string name, input logic [9:0] list [$]);
      int st, mr, ab;
      logic [31:0] ins;
      foreach (list[i]) begin
         bit          h;
         int          e_st, e_mr;
         logic [31:0] e_in;
         h    = model_hit(list[i]);
         e_mr = h ? 0 : mr_cycles();
         e_st = h ? 0 : 2 + mr_cycles();
         e_in = ref_word(list[i]);
         do_fetch(list[i], st, mr, ab, ins);
         model_fetch(list[i]);
         checks++;
         if (st !== e_st) begin errors++; $display("FAIL %s_stall: pc %0h got %0d want %0d", name, list[i], st, e_st); end
         checks++;
         if (mr !== e_mr) begin errors++; $display("FAIL %s_mem_read_cycles: pc %0h got %0d want %0d", name, list[i], mr, e_mr); end
         checks++;
         if (ab !== 0) begin errors++; $display("FAIL %s_mem_address: pc %0h got %0d bad cycles want 0", name, list[i], ab); end
         checks++;
         if (ins !== e_in) begin errors++; $display("FAIL %s_instruction: pc %0h got %0h want %0h", name, list[i], ins, e_in); end
      end
      checks++;
      if (hit_count !== exp_cnt(exp_hits) || miss_count !== exp_cnt(exp_miss)) begin
         errors++;
         $display("FAIL %s_counters: got %0h/%0h want %0h/%0h", name, hit_count, miss_count,
                  exp_cnt(exp_hits), exp_cnt(exp_miss));
      end
   endtask

   task automatic test_cold_miss();
      logic [9:0] l [$];
      int st, mr, ab;
      logic [31:0] ins;
      lat = 40;
      l = {10'h000};
      run_list("cold_miss", l);
      // the installed block must hold the known word regardless of the model
      lat = 0;
      do_fetch(10'h000, st, mr, ab, ins);
      model_fetch(10'h000);
      checks++;
      if (ins !== 32'h07000009 || st !== 0) begin
         errors++; $display("FAIL cold_miss_word: got %0h stall %0d want 07000009 stall 0", ins, st);
      end
   endtask

   task automatic test_hit_after_fill();
      logic [9:0] l [$];
      lat = 40;
      l = {10'h004, 10'h008, 10'h00C};
      run_list("hit_after_fill", l);
   endtask

   task automatic test_conflict();
      logic [9:0] l [$];
      pulse_reset();
      lat = 3;
      l = {10'h000, 10'h080, 10'h000};
      run_list("conflict", l);
      checks++;
      if (exp_miss != 3 || miss_count !== exp_cnt(3)) begin
         errors++; $display("FAIL conflict_miss_count: got %0h want %0h", miss_count, exp_cnt(3));
      end
   endtask

   task automatic test_pc_change();
      int stalls;
      int e_st;
      logic [9:0] a, b;
      logic [9:0] l [$];
      a = 10'h1A4;
      b = 10'h2F8;
      lat = 4;
      e_st = 2 * (2 + mr_cycles());
      @(negedge clock);
      read = 1'b1;
      pc   = a;
      @(negedge clock);
      #1;
      checks++;
      if (mem_read !== 1'b1 || mem_address !== a[9:4]) begin
         errors++; $display("FAIL pc_change_request: got %b/%0h want 1/%0h", mem_read, mem_address, a[9:4]);
      end
      pc = b;
      stalls = 1;
      #1;
      while (busywait === 1'b1 && stalls < 2000) begin
         @(negedge clock);
         #1;
         stalls++;
      end
      checks++;
      if (stalls !== e_st) begin errors++; $display("FAIL pc_change_stall: got %0d want %0d", stalls, e_st); end
      checks++;
      if (instruction !== ref_word(b)) begin
         errors++; $display("FAIL pc_change_instruction: got %0h want %0h", instruction, ref_word(b));
      end
      @(negedge clock);
      read = 1'b0;
      // A installed along the way without a hit of its own
      exp_miss += 2;
      exp_hits += 1;
      ref_v[a[6:4]] = 1'b1; ref_blk[a[6:4]] = a[9:4];
      ref_v[b[6:4]] = 1'b1; ref_blk[b[6:4]] = b[9:4];
      l = {a, b};
      run_list("pc_change_after", l);
   endtask

   task automatic test_random();
      logic [9:0] l [$];
      for (int n = 0; n < 40; n++) begin
         logic [9:0] a;
         a = {3'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         l = {a};
         lat = $urandom_range(0, 6);
         run_list("random", l);
      end
   endtask

   task automatic test_slow_memory();
      logic [9:0] l [$];
      lat = 100;
      l = {10'h35C, 10'h350};
      run_list("slow_memory", l);
   endtask

   task automatic test_reset_mid_refill();
      int waitc;
      logic [9:0] l [$];
      lat = 20;
      @(negedge clock);
      read = 1'b1;
      pc   = 10'h3C8;
      waitc = 0;
      #1;
      while (mem_read !== 1'b1 && waitc < 10) begin
         @(negedge clock);
         #1;
         waitc++;
      end
      checks++;
      if (mem_read !== 1'b1) begin errors++; $display("FAIL mid_refill_request: got %b want 1", mem_read); end
      repeat (3) @(negedge clock);
      #2;
      reset = 1'b0;
      read  = 1'b0;
      #1;
      checks++;
      if (mem_read !== 1'b0 || busywait !== 1'b0) begin
         errors++; $display("FAIL mid_refill_async: got mem_read %b busywait %b want 0 0", mem_read, busywait);
      end
      checks++;
      if (instruction !== 32'd0 || mem_address !== 6'd0 || hit_count !== 16'd0 || miss_count !== 16'd0) begin
         errors++; $display("FAIL mid_refill_clear: got %0h %0h %0h %0h want 0 0 0 0",
                            instruction, mem_address, hit_count, miss_count);
      end
      repeat (2) @(negedge clock);
      reset = 1'b1;
      model_reset();
      lat = 2;
      l = {10'h3C8};
      run_list("mid_refill_refetch", l);
   endtask

   task automatic test_stats_saturation();
      int bw;
      bw = 0;
      @(negedge clock);
      read = 1'b1;
      pc   = 10'h3C8;
      for (int i = 0; i < 70000; i++) begin
         @(negedge clock);
         #1;
         if (busywait !== 1'b0) bw++;
      end
      read = 1'b0;
      exp_hits += 70000;
      checks++;
      if (bw !== 0) begin errors++; $display("FAIL saturation_stalls: got %0d want 0", bw); end
      checks++;
      if (hit_count !== exp_cnt(exp_hits)) begin
         errors++; $display("FAIL saturation_hit_count: got %0h want %0h", hit_count, exp_cnt(exp_hits));
      end
      checks++;
      if (miss_count !== exp_cnt(exp_miss)) begin
         errors++; $display("FAIL saturation_miss_count: got %0h want %0h", miss_count, exp_cnt(exp_miss));
      end
   endtask

   initial begin
      reset = 1'b0;
      read  = 1'b0;
      pc    = '0;
      for (int i = 0; i < 1024; i++) memb[i] = 8'($urandom);
      set_word(0,  32'h07000009);
      set_word(4,  32'h07010001);
      set_word(8,  32'h0A000001);
      set_word(12, 32'h0B000100);
      model_reset();
      repeat (3) @(negedge clock);
      reset = 1'b1;

      test_reset();
      test_cold_miss();
      test_hit_after_fill();
      test_conflict();
      test_pc_change();
      test_random();
      test_slow_memory();
      test_reset_mid_refill();
      test_stats_saturation();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instruction_cache_ctrl.md
# instruction_cache_ctrl

Direct-mapped, read-only instruction cache and refill controller between the CPU fetch stage and the 1024-byte instruction memory (16-byte blocks, 6-bit block address, level-sensitive `read`/`busywait` handshake). Hits return a 32-bit instruction in the same cycle. Misses stall the CPU via `busywait`, fetch one 128-bit block, install it, and then complete as a hit.

## Interface
Parameters:
- `NUM_SETS`, 8: number of cache lines; fixed at 8 (3-bit index).
- `TAG_BITS`, 3: tag width; `pc[9:7]`.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low; 0 = reset.
- `read`  in  1  CPU fetch request; held high while `busywait` = 1.
- `pc`  in  10  byte address; `pc[1:0]` ignored.
- `instruction`  out  32  fetched instruction, valid when `read` = 1 and `busywait` = 0.
- `busywait`  out  1  CPU stall.
- `mem_read`  out  1  block read request to instruction memory.
- `mem_address`  out  6  block address, equal to `latched_pc[9:4]`.
- `mem_readinst`  in  128  block data; byte 0 in bits [7:0].
- `mem_busywait`  in  1  memory busy.
- `hit_count`  out  16  hit counter (see Configuration).
- `miss_count`  out  16  miss counter (see Configuration).

## Operation
- Address split:
  - word offset `pc[3:2]`
  - index `pc[6:4]`
  - tag `pc[9:7]`
- Storage per line: `valid` (1), `tag` (3), `data` (128).
- Hit: `valid[index] && tag[index] == pc[9:7]`. Evaluated combinationally.
- `instruction = data[index][32*offset +: 32]`.
- States:
  - IDLE:
    - If `read && hit`: `busywait` = 0.
    - If `read && !hit`: `busywait` = 1. At the next edge, latch `pc[9:4]` and go to MEM_READ.
  - MEM_READ:
    - `mem_read` = 1, `mem_address` = latched block, `busywait` = 1.
    - The entry cycle is mandatory.
    - From the second cycle on, the first edge that samples `mem_busywait` = 0 moves to UPDATE.
  - UPDATE:
    - `mem_read` = 0, `busywait` = 1.
    - At the edge, write `data` = `mem_readinst`, set `tag` = latched tag and `valid` = 1.
    - Go to IDLE.
- If `read` = 0 in IDLE: no state change, `busywait` = 0.
- `pc` changed during a refill:
  - The latched block is still installed.
  - The lookup then re-evaluates against the current `pc`, and a second miss refills normally.
- A refill overwrites the line unconditionally. There is no dirty state (read-only).

## Timing
- Reset values:
  - state IDLE
  - all `valid` = 0
  - `mem_read` = 0, `mem_address` = 0
  - `busywait` = 0
  - `instruction` = 0 while no line is valid
  - counters = 0
- Reset mid-refill: `mem_read` drops asynchronously. The partial fill is discarded and the line stays invalid.
- Hit latency: 0 cycles. The instruction is valid combinationally in the cycle `read` rises.
- Miss latency:
  - 1 cycle IDLE detect
  - ≥ 2 cycles MEM_READ
  - 1 cycle UPDATE
  - 0-cycle hit in the following IDLE
- `busywait` is combinational from `read`, `pc`, and state. It never glitches high on a stable hit.
- `mem_read` is registered; it rises only on the IDLE→MEM_READ edge.

## Configuration
- `ICACHE_STATS_EN` defined:
  - `hit_count` increments on each edge in IDLE with `read && hit`.
  - `miss_count` increments on each IDLE→MEM_READ transition.
  - Both are 16-bit, saturate at 0xFFFF, and clear on reset.
- Not defined: both ports are tied to 0 and no counter flops are built.

## Test plan
- Cold miss:
  - Stimulus: reset, then `read` = 1, `pc` = 0x000, with the memory model returning block 0 after 40 cycles.
  - Required: `busywait` high, `mem_read` high with `mem_address` = 0, then `busywait` low with `instruction` = 0x07000009.
- Hit after fill:
  - Stimulus: `pc` = 0x004, 0x008, 0x00C.
  - Required: 0x07010001, 0x0A000001, 0x0B000100, zero stall cycles, `mem_read` stays 0.
- Conflict eviction:
  - Stimulus: fetch `pc` = 0x000, then `pc` = 0x080 (same index, tag 1), then 0x000.
  - Required: three refills, each with correct data, `miss_count` = 3 with `ICACHE_STATS_EN`.
- Reset mid-refill:
  - Stimulus: pull `reset` low during MEM_READ.
  - Required: `mem_read` = 0 and `busywait` = 0 immediately; the next fetch of the same `pc` misses again.
- Slow memory:
  - Stimulus: hold `mem_busywait` = 1 for 100 cycles.
  - Required: the FSM stays in MEM_READ and `busywait` stays 1 throughout; the line installs one edge after release.
- Stats saturation (`ICACHE_STATS_EN`):
  - Stimulus: 70000 consecutive hits.
  - Required: `hit_count` = 0xFFFF. Without the macro, both counters read 0.
